// File: rtl/ring_pkg.sv
// Shared types and helpers for the token-ring scheduler.
package ring_pkg;

  localparam int unsigned LAPS_W = 8;

  typedef enum logic [2:0] {
    StIdle,
    StGrant,
    StPass,
    StWaitAck,
    StFault
  } ring_state_e;

  function automatic int unsigned next_pos(input int unsigned pos, input int unsigned n);
    return (pos == n - 1) ? 0 : pos + 1;
  endfunction

endpackage

// File: rtl/ring_pass_retry.sv
// Ack timer and retry counter for one token pass; flags success, retryable fail or give-up.
module ring_pass_retry #(
  parameter int unsigned ACK_TIMEOUT = 4,
  parameter int unsigned MAX_RETRY   = 3
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_start,
  input  logic i_wait,
  input  logic i_ack,
  input  logic i_loss,
  output logic o_success,
  output logic o_fail,
  output logic o_give_up
);

  localparam int unsigned TimerW = $clog2(ACK_TIMEOUT + 1);
  localparam int unsigned RetryW = $clog2(MAX_RETRY + 1);

  logic [TimerW-1:0] r_timer;
  logic [RetryW-1:0] r_retry;
  logic              w_expired;
  logic              w_failed;
  logic              w_last;

  assign w_expired = (r_timer == TimerW'(ACK_TIMEOUT - 1));
  // Loss outranks an ack arriving in the same cycle.
  assign w_failed  = i_wait & (i_loss | (~i_ack & w_expired));
  assign w_last    = (r_retry == RetryW'(MAX_RETRY - 1));
  assign o_success = i_wait & ~i_loss & i_ack;
  assign o_fail    = w_failed & ~w_last;
  assign o_give_up = w_failed & w_last;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_timer <= '0;
      r_retry <= '0;
    end else begin
      if (i_start) begin
        r_timer <= '0;
      end else if (i_wait && !w_expired) begin
        r_timer <= r_timer + 1'b1;
      end

      if (o_success) begin
        r_retry <= '0;
      end else if (o_fail) begin
        r_retry <= r_retry + 1'b1;
      end
    end
  end

endmodule

// File: rtl/ring_token_sched.sv
// Token-passing scheduler: grants the medium to the token holder, bounds hold time,
// forwards the token with ack/retry, and latches a sticky fault after repeated failures.
module ring_token_sched
  import ring_pkg::*;
#(
  parameter int unsigned N           = 4,
  parameter int unsigned HOLD_MAX    = 8,
  parameter int unsigned ACK_TIMEOUT = 4,
  parameter int unsigned MAX_RETRY   = 3
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  input  logic [N-1:0]         i_req,
  input  logic [N-1:0]         i_done,
  input  logic                 i_ack,
  input  logic                 i_loss,
  output logic [N-1:0]         o_grant,
  output logic [$clog2(N)-1:0] o_token_pos,
  output logic                 o_pass_valid,
  output logic                 o_fault,
  output logic [LAPS_W-1:0]    o_laps
);

  localparam int unsigned PosW  = $clog2(N);
  localparam int unsigned HoldW = $clog2(HOLD_MAX + 1);

  ring_state_e       r_state;
  logic [PosW-1:0]   r_token_pos;
  logic [HoldW-1:0]  r_hold_cnt;
  logic [N-1:0]      r_grant;
  logic              r_pass_valid;
  logic              r_fault;
  logic [LAPS_W-1:0] r_laps;

  logic [N-1:0]      w_holder_oh;
  logic [PosW-1:0]   w_next_pos;
  logic              w_hold_last;
  logic              w_start;
  logic              w_wait;
  logic              w_success;
  logic              w_fail;
  logic              w_give_up;

  assign w_holder_oh = N'(1) << r_token_pos;
  assign w_next_pos  = PosW'(next_pos(32'(r_token_pos), N));
  assign w_hold_last = (r_hold_cnt == HoldW'(HOLD_MAX - 1));
  assign w_start     = (r_state == StPass);
  assign w_wait      = (r_state == StWaitAck);

  ring_pass_retry #(
    .ACK_TIMEOUT (ACK_TIMEOUT),
    .MAX_RETRY   (MAX_RETRY)
  ) u_pass_retry (
    .i_clk     (i_clk),
    .i_reset   (i_reset),
    .i_start   (w_start),
    .i_wait    (w_wait),
    .i_ack     (i_ack),
    .i_loss    (i_loss),
    .o_success (w_success),
    .o_fail    (w_fail),
    .o_give_up (w_give_up)
  );

  // Outputs are registered alongside the state so they always match the state being entered.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state      <= StIdle;
      r_token_pos  <= '0;
      r_hold_cnt   <= '0;
      r_grant      <= '0;
      r_pass_valid <= 1'b0;
      r_fault      <= 1'b0;
      r_laps       <= '0;
    end else begin
      unique case (r_state)
        StIdle: begin
          if (i_req[r_token_pos]) begin
            r_state    <= StGrant;
            r_hold_cnt <= '0;
            r_grant    <= w_holder_oh;
          end else begin
            r_state      <= StPass;
            r_pass_valid <= 1'b1;
          end
        end
        StGrant: begin
          r_hold_cnt <= r_hold_cnt + 1'b1;
          if (i_done[r_token_pos] || w_hold_last) begin
            r_state      <= StPass;
            r_grant      <= '0;
            r_pass_valid <= 1'b1;
          end
        end
        StPass: begin
          r_state      <= StWaitAck;
          r_pass_valid <= 1'b0;
        end
        StWaitAck: begin
          if (w_success) begin
            r_state     <= StIdle;
            r_token_pos <= w_next_pos;
            if (r_token_pos == PosW'(N - 1)) begin
              r_laps <= r_laps + 1'b1;
            end
          end else if (w_fail) begin
            r_state      <= StPass;
            r_pass_valid <= 1'b1;
          end else if (w_give_up) begin
            r_state <= StFault;
            r_fault <= 1'b1;
          end
        end
        StFault: begin
          r_state <= StFault;
        end
        default: begin
          r_state      <= StIdle;
          r_grant      <= '0;
          r_pass_valid <= 1'b0;
        end
      endcase
    end
  end

  assign o_grant      = r_grant;
  assign o_token_pos  = r_token_pos;
  assign o_pass_valid = r_pass_valid;
  assign o_fault      = r_fault;
  assign o_laps       = r_laps;

endmodule

// File: tb/tb_ring_token_sched.sv
// Scenario bench for ring_token_sched; pass strobes are matched against a queue of expected holders.
module tb_ring_token_sched;

  localparam int unsigned N = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] req;
  logic [3:0] done;
  logic       ack;
  logic       loss;
  logic [3:0] grant;
  logic [1:0] token_pos;
  logic       pass_valid;
  logic       fault;
  logic [7:0] laps;

  int         n_checks = 0;
  int         n_err = 0;
  logic [1:0] exp_q[$];
  logic [1:0] mon_exp;

  ring_token_sched #(
    .N           (4),
    .HOLD_MAX    (8),
    .ACK_TIMEOUT (4),
    .MAX_RETRY   (3)
  ) dut (
    .i_clk        (clk),
    .i_reset      (reset),
    .i_req        (req),
    .i_done       (done),
    .i_ack        (ack),
    .i_loss       (loss),
    .o_grant      (grant),
    .o_token_pos  (token_pos),
    .o_pass_valid (pass_valid),
    .o_fault      (fault),
    .o_laps       (laps)
  );

  always #5 clk = ~clk;

  // Every pass strobe must match the next expected sender.
  always @(negedge clk) begin
    if (pass_valid === 1'b1) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL pass_strobe: got pass_valid at token_pos=%0d, expected no pass", token_pos);
      end else begin
        mon_exp = exp_q.pop_front();
        if (token_pos !== mon_exp) begin
          n_err++;
          $display("FAIL pass_strobe: token_pos=%0d, expected %0d", token_pos, mon_exp);
        end
      end
    end
  end

  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b1; req = '0; done = '0; ack = 1'b0; loss = 1'b0;
    repeat (3) cyc();
    n_checks++;
    if ({grant, token_pos, pass_valid, fault, laps} !== 16'h0) begin
      n_err++;
      $display("FAIL reset_state: grant=%b pos=%0d pv=%b fault=%b laps=%0d, expected all 0",
               grant, token_pos, pass_valid, fault, laps);
    end
    reset = 1'b0;
  endtask

  task automatic test_idle_laps();
    for (int h = 0; h < 4; h++) begin
      exp_q.push_back(2'(h));
      cyc();
      n_checks++;
      if (grant !== 4'b0000) begin
        n_err++;
        $display("FAIL idle_grant: grant=%b, expected 0000", grant);
      end
      cyc();
      ack = 1'b1;
      cyc();
      ack = 1'b0;
      n_checks++;
      if (token_pos !== 2'((h + 1) % 4)) begin
        n_err++;
        $display("FAIL idle_step: token_pos=%0d, expected %0d", token_pos, (h + 1) % 4);
      end
    end
    n_checks++;
    if (laps !== 8'd1) begin
      n_err++;
      $display("FAIL idle_laps: laps=%0d, expected 1", laps);
    end
  endtask

  task automatic test_grant_done();
    req = 4'b0001;
    for (int c = 1; c <= 3; c++) begin
      cyc();
      done = (c == 1) ? 4'b0010 : (c == 3) ? 4'b0001 : 4'b0000;
      n_checks++;
      if (grant !== 4'b0001) begin
        n_err++;
        $display("FAIL grant_done_cycle%0d: grant=%b, expected 0001", c, grant);
      end
    end
    exp_q.push_back(2'd0);
    cyc();
    done = '0; req = '0;
    n_checks++;
    if (grant !== 4'b0000) begin
      n_err++;
      $display("FAIL grant_done_release: grant=%b, expected 0000", grant);
    end
    cyc();
    ack = 1'b1;
    cyc();
    ack = 1'b0;
    n_checks++;
    if (token_pos !== 2'd1) begin
      n_err++;
      $display("FAIL grant_done_advance: token_pos=%0d, expected 1", token_pos);
    end
  endtask

  task automatic test_grant_limit();
    exp_q.push_back(2'd1);
    cyc();
    cyc();
    ack = 1'b1;
    cyc();
    ack = 1'b0;
    req = 4'b0100;
    for (int c = 1; c <= 8; c++) begin
      cyc();
      if (c == 2) req = '0;
      n_checks++;
      if (grant !== 4'b0100) begin
        n_err++;
        $display("FAIL grant_limit_cycle%0d: grant=%b, expected 0100", c, grant);
      end
    end
    exp_q.push_back(2'd2);
    cyc();
    n_checks++;
    if (grant !== 4'b0000 || pass_valid !== 1'b1) begin
      n_err++;
      $display("FAIL grant_limit_end: grant=%b pv=%b, expected 0000 1", grant, pass_valid);
    end
    cyc();
    ack = 1'b1;
    cyc();
    ack = 1'b0;
  endtask

  task automatic test_loss_retry();
    exp_q.push_back(2'd3);
    cyc();
    cyc();
    loss = 1'b1;
    exp_q.push_back(2'd3);
    cyc();
    loss = 1'b0;
    n_checks++;
    if (token_pos !== 2'd3 || pass_valid !== 1'b1) begin
      n_err++;
      $display("FAIL loss_retransmit: pos=%0d pv=%b, expected 3 1", token_pos, pass_valid);
    end
    cyc();
    ack = 1'b1;
    cyc();
    ack = 1'b0;
    n_checks++;
    if (token_pos !== 2'd0 || laps !== 8'd2 || fault !== 1'b0) begin
      n_err++;
      $display("FAIL loss_recover: pos=%0d laps=%0d fault=%b, expected 0 2 0",
               token_pos, laps, fault);
    end
  endtask

  task automatic test_ack_and_loss();
    exp_q.push_back(2'd0);
    cyc();
    cyc();
    ack = 1'b1; loss = 1'b1;
    exp_q.push_back(2'd0);
    cyc();
    ack = 1'b0; loss = 1'b0;
    n_checks++;
    if (token_pos !== 2'd0 || pass_valid !== 1'b1) begin
      n_err++;
      $display("FAIL ack_loss_same: pos=%0d pv=%b, expected 0 1", token_pos, pass_valid);
    end
    cyc();
    ack = 1'b1;
    cyc();
    ack = 1'b0;
    n_checks++;
    if (token_pos !== 2'd1) begin
      n_err++;
      $display("FAIL ack_loss_advance: token_pos=%0d, expected 1", token_pos);
    end
  endtask

  task automatic test_timeout_fault();
    int strobes[3];
    int ns = 0;
    repeat (3) exp_q.push_back(2'd1);
    for (int c = 1; c <= 16; c++) begin
      cyc();
      if (pass_valid === 1'b1) begin
        if (ns < 3) strobes[ns] = c;
        ns++;
      end
      if (c == 15) begin
        n_checks++;
        if (fault !== 1'b0) begin
          n_err++;
          $display("FAIL timeout_early_fault: fault=%b at cycle 15, expected 0", fault);
        end
      end
    end
    n_checks++;
    if (fault !== 1'b1) begin
      n_err++;
      $display("FAIL timeout_fault: fault=%b at cycle 16, expected 1", fault);
    end
    n_checks++;
    if (ns != 3 || strobes[0] != 1 || strobes[1] != 6 || strobes[2] != 11) begin
      n_err++;
      $display("FAIL timeout_strobes: count=%0d at %0d,%0d,%0d, expected 3 at 1,6,11",
               ns, strobes[0], strobes[1], strobes[2]);
    end
    ack = 1'b1; req = 4'hF; done = 4'hF;
    for (int c = 0; c < 5; c++) begin
      loss = c[0];
      cyc();
      n_checks++;
      if (fault !== 1'b1 || grant !== 4'b0000 || pass_valid !== 1'b0 || token_pos !== 2'd1) begin
        n_err++;
        $display("FAIL fault_sticky: fault=%b grant=%b pv=%b pos=%0d, expected 1 0000 0 1",
                 fault, grant, pass_valid, token_pos);
      end
    end
    ack = 1'b0; req = '0; done = '0; loss = 1'b0;
  endtask

  task automatic test_reset_recover();
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    req = 4'b0001;
    n_checks++;
    if (fault !== 1'b0 || token_pos !== 2'd0 || laps !== 8'd0 || grant !== 4'b0000) begin
      n_err++;
      $display("FAIL reset_recover: fault=%b pos=%0d laps=%0d grant=%b, expected 0 0 0 0000",
               fault, token_pos, laps, grant);
    end
    cyc();
    cyc();
    n_checks++;
    if (grant !== 4'b0001) begin
      n_err++;
      $display("FAIL regrant: grant=%b, expected 0001", grant);
    end
    reset = 1'b1;
    cyc();
    n_checks++;
    if (grant !== 4'b0000 || pass_valid !== 1'b0) begin
      n_err++;
      $display("FAIL reset_mid_grant: grant=%b pv=%b, expected 0000 0", grant, pass_valid);
    end
    req = '0;
    cyc();
  endtask

  initial begin
    test_reset();
    test_idle_laps();
    test_grant_done();
    test_grant_limit();
    test_loss_retry();
    test_ack_and_loss();
    test_timeout_fault();
    test_reset_recover();
    n_checks++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL pass_drain: %0d expected passes never seen, expected 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "timeout");
  end

endmodule
